// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
package rf_wb_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int NREG   = 32;
   localparam int DW_DEF = 32;

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MD   = 2'd2
   } wb_src_e;

   // r0 is hardwired to zero, so writes and pending marks for it are dropped.
   function automatic logic is_real_reg(input reg_idx_t r);
      return r != REG_ZERO;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback, mul/div handshake, scoreboard query and register-file write bus.
interface rf_wb_arbiter_if
   import rf_wb_arbiter_pkg::*;
   #(parameter int DW = DW_DEF);

   logic          alu_valid;
   reg_idx_t      alu_wn;
   logic [DW-1:0] alu_wd;
   logic          alu_hold;

   logic          md_valid;
   logic          md_ready;
   reg_idx_t      md_wn;
   logic [DW-1:0] md_wd;

   logic          iss_set;
   reg_idx_t      iss_wn;

   reg_idx_t      q_rs1;
   reg_idx_t      q_rs2;
   reg_idx_t      q_rd;
   logic          stall;

   logic          rf_w;
   reg_idx_t      rf_wn;
   logic [DW-1:0] rf_wd;

   modport master (
      output alu_valid, alu_wn, alu_wd,
      input  alu_hold,
      output md_valid, md_wn, md_wd,
      input  md_ready,
      output iss_set, iss_wn,
      output q_rs1, q_rs2, q_rd,
      input  stall,
      input  rf_w, rf_wn, rf_wd
   );

   modport slave (
      input  alu_valid, alu_wn, alu_wd,
      output alu_hold,
      input  md_valid, md_wn, md_wd,
      output md_ready,
      input  iss_set, iss_wn,
      input  q_rs1, q_rs2, q_rd,
      output stall,
      output rf_w, rf_wn, rf_wd
   );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard: one bit per register still owed by mul/div.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     set_en,
   input  reg_idx_t set_wn,
   input  logic     clr_en,
   input  reg_idx_t clr_wn,
   input  reg_idx_t q_rs1,
   input  reg_idx_t q_rs2,
   input  reg_idx_t q_rd,
   output logic     stall
);

   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;

   // Clear is applied first so a same-edge re-issue keeps the register pending.
   always_comb begin
      pend_nxt = pend;
      if (clr_en) pend_nxt[clr_wn] = 1'b0;
      if (set_en && is_real_reg(set_wn)) pend_nxt[set_wn] = 1'b1;
      pend_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   assign stall = pend[q_rs1] | pend[q_rs2] | pend[q_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU writeback
// (no back-pressure) and the mul/div result (valid/ready), with anti-starvation.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int STARVE_MAX = 4,
   parameter int CW         = 4
) (
   input logic            clk,
   input logic            rst,
   rf_wb_arbiter_if.slave wb
);

   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic          md_ready_c;
   logic          md_xfer;
   wb_src_e       src_p0;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_nxt;
   logic          alu_hold_q;

   logic          vld_p1;
   reg_idx_t      rf_wn_p1;
   logic [DW-1:0] rf_wd_p1;
   logic          md_out_p1;

   // ---- stage p0: arbitration on the incoming writeback requests ----
   assign md_ready_c = !wb.alu_valid || alu_hold_q;
   assign md_xfer    = wb.md_valid && md_ready_c;

   // While frozen, any ALU data that still arrives is dropped.
   always_comb begin
      src_p0 = SRC_NONE;
      if (md_xfer)                        src_p0 = SRC_MD;
      else if (wb.alu_valid && !alu_hold_q) src_p0 = SRC_ALU;
   end

   always_comb begin
      wait_nxt = wait_cnt;
      if (md_xfer || !wb.md_valid)      wait_nxt = '0;
      else if (wait_cnt != STARVE_LIM)  wait_nxt = wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt   <= '0;
         alu_hold_q <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         if (md_xfer)                     alu_hold_q <= 1'b0;
         else if (wait_nxt == STARVE_LIM) alu_hold_q <= 1'b1;
      end
   end

   // ---- stage p1: registered write port towards the register file ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         rf_wn_p1  <= REG_ZERO;
         rf_wd_p1  <= '0;
         md_out_p1 <= 1'b0;
      end else begin
         vld_p1    <= 1'b0;
         md_out_p1 <= 1'b0;
         case (src_p0)
            SRC_MD: begin
               vld_p1    <= is_real_reg(wb.md_wn);
               rf_wn_p1  <= wb.md_wn;
               rf_wd_p1  <= wb.md_wd;
               md_out_p1 <= 1'b1;
            end
            SRC_ALU: begin
               vld_p1   <= is_real_reg(wb.alu_wn);
               rf_wn_p1 <= wb.alu_wn;
               rf_wd_p1 <= wb.alu_wd;
            end
            default: ;
         endcase
      end
   end

   // Pending bit drops on the same edge that the register file commits the md write.
   rf_scoreboard u_sb (
      .clk    (clk),
      .rst    (rst),
      .set_en (wb.iss_set),
      .set_wn (wb.iss_wn),
      .clr_en (md_out_p1),
      .clr_wn (rf_wn_p1),
      .q_rs1  (wb.q_rs1),
      .q_rs2  (wb.q_rs2),
      .q_rd   (wb.q_rd),
      .stall  (wb.stall)
   );

   assign wb.md_ready = md_ready_c;
   assign wb.alu_hold = alu_hold_q;
   assign wb.rf_w     = vld_p1;
   assign wb.rf_wn    = rf_wn_p1;
   assign wb.rf_wd    = rf_wd_p1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

   localparam int SM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   rf_wb_arbiter_if #(.DW(32)) bus ();

   rf_wb_arbiter #(.DW(32), .STARVE_MAX(SM), .CW(4)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   bit        m_w;
   bit [4:0]  m_wn;
   bit [31:0] m_wd;
   bit        m_hold;
   int        m_wait;
   bit        m_last_md;
   bit        m_pend [32];
   bit        md_accepted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_w = 0; m_wn = 0; m_wd = 0; m_hold = 0; m_wait = 0; m_last_md = 0;
      md_accepted = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
   endtask

   function automatic bit m_stall();
      return m_pend[bus.q_rs1] | m_pend[bus.q_rs2] | m_pend[bus.q_rd];
   endfunction

   task automatic idle();
      bus.alu_valid = 0; bus.alu_wn = 0; bus.alu_wd = 0;
      bus.md_valid  = 0; bus.md_wn  = 0; bus.md_wd  = 0;
      bus.iss_set   = 0; bus.iss_wn = 0;
      bus.q_rs1 = 0; bus.q_rs2 = 0; bus.q_rd = 0;
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic step();
      bit rdy, xfer, old_hold;
      #1;
      old_hold = m_hold;
      rdy  = !bus.alu_valid || old_hold;
      xfer = bus.md_valid && rdy;
      chk("md_ready", bus.md_ready, rdy);
      chk("stall", bus.stall, m_stall());
      chk("alu_contract", bus.alu_valid && bus.alu_hold, 0);
      chk("iss_legal", bus.iss_set && bus.iss_wn != 0 && m_pend[bus.iss_wn]
                       && !(m_last_md && m_wn == bus.iss_wn), 0);
      if (m_last_md) m_pend[m_wn] = 0;
      if (bus.iss_set && bus.iss_wn != 0) m_pend[bus.iss_wn] = 1;
      m_pend[0] = 0;
      if (xfer) begin
         m_w = (bus.md_wn != 0); m_wn = bus.md_wn; m_wd = bus.md_wd; m_last_md = 1;
      end else if (bus.alu_valid && !old_hold) begin
         m_w = (bus.alu_wn != 0); m_wn = bus.alu_wn; m_wd = bus.alu_wd; m_last_md = 0;
      end else begin
         m_w = 0; m_last_md = 0;
      end
      if (xfer || !bus.md_valid) m_wait = 0;
      else if (m_wait < SM) m_wait++;
      if (xfer) m_hold = 0;
      else if (m_wait == SM) m_hold = 1;
      md_accepted = xfer;
      @(posedge clk);
      #1;
      chk("rf_w", bus.rf_w, m_w);
      chk("rf_wn", bus.rf_wn, m_wn);
      chk("rf_wd", bus.rf_wd, m_wd);
      chk("alu_hold", bus.alu_hold, m_hold);
   endtask

   bit        md_busy;
   bit [4:0]  md_r;
   bit [31:0] md_d;
   bit [4:0]  inflight [$];

   initial begin
      bit [4:0] r;
      idle();
      model_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Test 1: asynchronous reset mid-cycle, then ALU write latency
      bus.alu_valid = 1; bus.alu_wn = 5'd4; bus.alu_wd = 32'h1111;
      bus.iss_set = 1; bus.iss_wn = 5'd12; bus.q_rs1 = 5'd12;
      step();
      idle(); bus.q_rs1 = 5'd12;
      #2 rst = 1;
      #1;
      chk("rst_rf_w", bus.rf_w, 0);
      chk("rst_rf_wn", bus.rf_wn, 0);
      chk("rst_rf_wd", bus.rf_wd, 0);
      chk("rst_alu_hold", bus.alu_hold, 0);
      chk("rst_stall", bus.stall, 0);
      #2 rst = 0;
      model_reset();
      idle();
      bus.alu_valid = 1; bus.alu_wn = 5'd5; bus.alu_wd = 32'hDEADBEEF;
      step();
      chk("t1_rf_w", bus.rf_w, 1);
      chk("t1_rf_wn", bus.rf_wn, 5);
      chk("t1_rf_wd", bus.rf_wd, 32'hDEADBEEF);

      // Test 2: md write with ALU idle
      idle();
      bus.md_valid = 1; bus.md_wn = 5'd7; bus.md_wd = 32'h12;
      #1 chk("t2_md_ready", bus.md_ready, 1);
      step();
      chk("t2_rf_w", bus.rf_w, 1);
      chk("t2_rf_wn", bus.rf_wn, 7);
      chk("t2_rf_wd", bus.rf_wd, 32'h12);
      idle();
      step();

      // Test 3: starvation forces alu_hold
      bus.md_valid = 1; bus.md_wn = 5'd3; bus.md_wd = 32'h33;
      bus.alu_valid = 1; bus.alu_wn = 5'd20; bus.alu_wd = 32'hA0;
      #1 chk("t3_md_ready0", bus.md_ready, 0);
      for (int i = 1; i <= SM; i++) begin
         bus.alu_wn = 5'(20 + i); bus.alu_wd = 32'hA0 + i;
         step();
         if (i < SM) begin
            chk("t3_md_ready_starved", bus.md_ready, 0);
            chk("t3_hold_low", bus.alu_hold, 0);
         end
      end
      chk("t3_hold_high", bus.alu_hold, 1);
      bus.alu_valid = 0;
      #1 chk("t3_md_ready1", bus.md_ready, 1);
      step();
      chk("t3_rf_w", bus.rf_w, 1);
      chk("t3_rf_wn", bus.rf_wn, 3);
      chk("t3_rf_wd", bus.rf_wd, 32'h33);
      chk("t3_hold_clear", bus.alu_hold, 0);
      idle();
      step();

      // Test 4: scoreboard stall until md commit
      bus.iss_set = 1; bus.iss_wn = 5'd9; bus.q_rs1 = 5'd9;
      step();
      chk("t4_stall_set", bus.stall, 1);
      bus.iss_set = 0;
      step(); step();
      chk("t4_stall_wait", bus.stall, 1);
      bus.md_valid = 1; bus.md_wn = 5'd9; bus.md_wd = 32'h99;
      step();
      chk("t4_rf_wn", bus.rf_wn, 9);
      chk("t4_stall_commit", bus.stall, 1);
      bus.md_valid = 0;
      step();
      chk("t4_stall_clear", bus.stall, 0);

      // Test 5: re-issue on the commit edge keeps the register pending
      bus.iss_set = 1; bus.iss_wn = 5'd9;
      step();
      bus.iss_set = 0;
      bus.md_valid = 1; bus.md_wn = 5'd9; bus.md_wd = 32'h55;
      step();
      bus.md_valid = 0;
      bus.iss_set = 1; bus.iss_wn = 5'd9;
      step();
      chk("t5_stall_kept", bus.stall, 1);
      bus.iss_set = 0;
      bus.md_valid = 1; bus.md_wd = 32'h56;
      step();
      bus.md_valid = 0;
      step();
      chk("t5_stall_clear", bus.stall, 0);

      // Test 6: r0 writes are accepted but dropped
      idle();
      bus.md_valid = 1; bus.md_wn = 5'd0; bus.md_wd = 32'h77;
      #1 chk("t6_md_ready", bus.md_ready, 1);
      step();
      chk("t6_md_r0", bus.rf_w, 0);
      idle();
      bus.alu_valid = 1; bus.alu_wn = 5'd0; bus.alu_wd = 32'h88;
      step();
      chk("t6_alu_r0", bus.rf_w, 0);
      idle();
      bus.iss_set = 1; bus.iss_wn = 5'd0;
      step();
      chk("t6_stall_r0", bus.stall, 0);
      idle();
      step();

      // Randomized traffic with a well-behaved mul/div unit and pipeline
      md_busy = 0;
      inflight.delete();
      for (int c = 0; c < 3000; c++) begin
         if (md_accepted) md_busy = 0;
         if (!md_busy && inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            md_r = inflight.pop_front();
            md_d = $urandom;
            md_busy = 1;
         end
         bus.md_valid = md_busy; bus.md_wn = md_r; bus.md_wd = md_d;
         bus.alu_valid = m_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
         bus.alu_wn = 5'($urandom_range(0, 31));
         bus.alu_wd = $urandom;
         r = 5'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0 && !m_pend[r] && inflight.size() < 4) begin
            bus.iss_set = 1; bus.iss_wn = r;
            inflight.push_back(r);
         end else begin
            bus.iss_set = 0; bus.iss_wn = 5'($urandom_range(0, 31));
         end
         bus.q_rs1 = 5'($urandom_range(0, 15));
         bus.q_rs2 = 5'($urandom_range(0, 15));
         bus.q_rd  = 5'($urandom_range(0, 15));
         step();
      end

      // Reset mid-operation drops pending state
      #2 rst = 1;
      #1;
      chk("rst2_rf_w", bus.rf_w, 0);
      chk("rst2_alu_hold", bus.alu_hold, 0);
      for (int i = 0; i < 32; i++) begin
         bus.q_rs1 = 5'(i); bus.q_rs2 = 5'(i); bus.q_rd = 5'(i);
         #0.1 chk("rst2_stall", bus.stall, 0);
      end
      idle();
      @(negedge clk);
      rst = 0;
      model_reset();
      md_busy = 0;
      inflight.delete();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
